// File: rtl/pipelined_phase_accumulator_if.sv
// Sample/result bundle of the pipelined phase accumulator.
// master = FTW source side, slave = accumulator side.
interface pipelined_phase_accumulator_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         clr;
  logic [N-1:0] ftw_in;
  logic [N-1:0] phase_out;
  logic         out_valid;
  logic         wrap_out;

  modport master (
    output in_valid, clr, ftw_in,
    input  phase_out, out_valid, wrap_out
  );

  modport slave (
    input  in_valid, clr, ftw_in,
    output phase_out, out_valid, wrap_out
  );
endinterface

// File: rtl/pipelined_phase_accumulator.sv
// NCO phase accumulator split into S = N/SEG carry-registered segments.
// Each pipe stage carries one N-bit word: finished result slices below the active segment, pending FTW slices above.
module pipelined_phase_accumulator #(
  parameter int N   = 32,
  parameter int SEG = 8
) (
  input logic                        clk,
  input logic                        rst,
  pipelined_phase_accumulator_if.slave bus
);
  localparam int S = N / SEG;

  logic           valid_p_r [0:S];
  logic           clr_p_r   [0:S-1];
  logic           carry_p_r [0:S];
  logic [N-1:0]   data_p_r  [0:S];
  logic [SEG-1:0] acc_r     [0:S-1];

  logic [SEG-1:0] new_slice_s [0:S-1];
  logic           carry_s     [0:S-1];
  logic [N-1:0]   next_data_s [0:S-1];

  // Segment adders: a clear loads the FTW slice and kills the carry chain for that sample.
  always_comb begin
    logic [SEG:0] sum_v;
    sum_v = {(SEG+1){1'b0}};
    for (int j = 0; j < S; j++) begin
      sum_v          = {1'b0, acc_r[j]} + {1'b0, data_p_r[j][j*SEG +: SEG]}
                     + {{SEG{1'b0}}, carry_p_r[j]};
      new_slice_s[j] = clr_p_r[j] ? data_p_r[j][j*SEG +: SEG] : sum_v[SEG-1:0];
      carry_s[j]     = clr_p_r[j] ? 1'b0 : sum_v[SEG];
      next_data_s[j] = data_p_r[j];
      next_data_s[j][j*SEG +: SEG] = new_slice_s[j];
    end
  end

  // Input stage, skew/deskew pipe and accumulator slices.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j <= S; j++) begin
        valid_p_r[j] <= 1'b0;
        carry_p_r[j] <= 1'b0;
        data_p_r[j]  <= {N{1'b0}};
      end
      for (int j = 0; j < S; j++) begin
        clr_p_r[j] <= 1'b0;
        acc_r[j]   <= {SEG{1'b0}};
      end
    end else begin
      valid_p_r[0] <= bus.in_valid;
      clr_p_r[0]   <= bus.in_valid & bus.clr;
      carry_p_r[0] <= 1'b0;
      data_p_r[0]  <= bus.ftw_in;
      for (int j = 0; j < S; j++) begin
        valid_p_r[j+1] <= valid_p_r[j];
        carry_p_r[j+1] <= valid_p_r[j] & carry_s[j];
        data_p_r[j+1]  <= next_data_s[j];
        // Slices only move for real samples, so bubbles never disturb the phase.
        if (valid_p_r[j]) begin
          acc_r[j] <= new_slice_s[j];
        end else begin
          acc_r[j] <= acc_r[j];
        end
      end
      for (int j = 0; j < S - 1; j++) begin
        clr_p_r[j+1] <= clr_p_r[j];
      end
    end
  end

  // Output register: phase holds across bubbles, wrap is a one-cycle flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.phase_out <= {N{1'b0}};
      bus.out_valid <= 1'b0;
      bus.wrap_out  <= 1'b0;
    end else begin
      bus.out_valid <= valid_p_r[S];
      bus.wrap_out  <= valid_p_r[S] & carry_p_r[S];
      if (valid_p_r[S]) begin
        bus.phase_out <= data_p_r[S];
      end else begin
        bus.phase_out <= bus.phase_out;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_phase_accumulator.sv
// Scoreboard bench for three accumulator configurations: 32/8, 16/4 and 32/32.
// A behavioural reference pushes expected results with their due cycle; outputs are popped and compared on the falling edge.
module tb_pipelined_phase_accumulator;
  typedef struct {
    logic [31:0] phase;
    logic        wrap;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  logic chk_en;
  int   cyc;
  int   checks;
  int   errors;

  exp_t        exp_q  [0:2][$];
  logic [31:0] acc_m  [0:2];
  logic [31:0] last_ph[0:2];
  int          n_of   [0:2];
  int          lat_of [0:2];

  pipelined_phase_accumulator_if #(.N(32)) ifa ();
  pipelined_phase_accumulator_if #(.N(16)) ifb ();
  pipelined_phase_accumulator_if #(.N(32)) ifc ();

  pipelined_phase_accumulator #(.N(32), .SEG(8))  u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pipelined_phase_accumulator #(.N(16), .SEG(4))  u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  pipelined_phase_accumulator #(.N(32), .SEG(32)) u_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Apply one cycle of stimulus to configuration id and push the reference result.
  task automatic drive(input int id, input logic v, input logic c, input logic [31:0] f_in);
    logic [32:0] s;
    logic [31:0] mask;
    logic [31:0] f;
    exp_t        e;
    mask = (n_of[id] == 32) ? 32'hFFFF_FFFF : ((32'd1 << n_of[id]) - 32'd1);
    f    = f_in & mask;
    case (id)
      0: begin ifa.in_valid = v; ifa.clr = c; ifa.ftw_in = f; end
      1: begin ifb.in_valid = v; ifb.clr = c; ifb.ftw_in = f[15:0]; end
      2: begin ifc.in_valid = v; ifc.clr = c; ifc.ftw_in = f; end
      default: ;
    endcase
    if (v) begin
      if (c) begin
        e.phase = f;
        e.wrap  = 1'b0;
      end else begin
        s       = {1'b0, acc_m[id]} + {1'b0, f};
        e.wrap  = s[n_of[id]];
        e.phase = s[31:0] & mask;
      end
      acc_m[id] = e.phase;
      e.due     = cyc + 1 + lat_of[id];
      exp_q[id].push_back(e);
    end
  endtask

  task automatic check_port(input int id, input logic ov, input logic [31:0] ph, input logic wr);
    exp_t e;
    if (ov) begin
      if (exp_q[id].size() == 0) begin
        check_val($sformatf("cfg%0d.unexpected_valid", id), {63'd0, ov}, 64'd0);
      end else begin
        e = exp_q[id].pop_front();
        check_val($sformatf("cfg%0d.latency", id), 64'(cyc), 64'(e.due));
        check_val($sformatf("cfg%0d.phase", id), {32'd0, ph}, {32'd0, e.phase});
        check_val($sformatf("cfg%0d.wrap", id), {63'd0, wr}, {63'd0, e.wrap});
        last_ph[id] = e.phase;
      end
    end else begin
      if (exp_q[id].size() != 0 && exp_q[id][0].due <= cyc) begin
        check_val($sformatf("cfg%0d.missing_valid", id), {63'd0, ov}, 64'd1);
        e = exp_q[id].pop_front();
        last_ph[id] = e.phase;
      end
      check_val($sformatf("cfg%0d.hold_phase", id), {32'd0, ph}, {32'd0, last_ph[id]});
      check_val($sformatf("cfg%0d.idle_wrap", id), {63'd0, wr}, 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst && chk_en) begin
      check_port(0, ifa.out_valid, ifa.phase_out, ifa.wrap_out);
      check_port(1, ifb.out_valid, 32'(ifb.phase_out), ifb.wrap_out);
      check_port(2, ifc.out_valid, ifc.phase_out, ifc.wrap_out);
    end
  end

  task automatic step(input logic v, input logic c, input logic [31:0] f);
    drive(0, v, c, f);
    drive(1, 1'b0, 1'b0, 32'd0);
    drive(2, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
  endtask

  // Drop reset between clock edges and check the outputs clear without waiting for a clock.
  task automatic apply_reset();
    for (int id = 0; id < 3; id++) drive(id, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int id = 0; id < 3; id++) begin
      exp_q[id].delete();
      acc_m[id]   = 32'd0;
      last_ph[id] = 32'd0;
    end
    #1;
    check_val("rst.a.phase", {32'd0, ifa.phase_out}, 64'd0);
    check_val("rst.a.valid", {63'd0, ifa.out_valid}, 64'd0);
    check_val("rst.a.wrap",  {63'd0, ifa.wrap_out}, 64'd0);
    check_val("rst.b.phase", {48'd0, ifb.phase_out}, 64'd0);
    check_val("rst.c.valid", {63'd0, ifc.out_valid}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic        v;
    logic        c;
    logic [31:0] f;
    int          sel;
    checks = 0;
    errors = 0;
    cyc    = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    n_of   = '{32, 16, 32};
    lat_of = '{5, 5, 2};
    for (int id = 0; id < 3; id++) begin
      acc_m[id]   = 32'd0;
      last_ph[id] = 32'd0;
    end
    @(negedge clk);
    apply_reset();
    chk_en = 1'b1;

    // Increment by one, first result after five cycles
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h1);
    idle(6);
    // Carry rippling across every segment
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 32'h0000_0001);
    step(1'b1, 1'b0, 32'h00FF_FFFF);
    step(1'b1, 1'b0, 32'h0000_0001);
    idle(6);
    // Bubbles
    step(1'b1, 1'b1, 32'h10);
    step(1'b0, 1'b0, 32'h10);
    step(1'b0, 1'b0, 32'h10);
    step(1'b1, 1'b0, 32'h10);
    step(1'b1, 1'b0, 32'h10);
    idle(6);
    // Clear mid-stream
    step(1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b0, 32'h100);
    step(1'b1, 1'b0, 32'h100);
    step(1'b1, 1'b1, 32'h5);
    step(1'b1, 1'b0, 32'h100);
    // Consecutive clears, zero FTW, all-ones FTW
    step(1'b1, 1'b1, 32'h3);
    step(1'b1, 1'b1, 32'h9);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 32'hFFFF_FFFF);
    idle(6);
    // Reset with samples in flight
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h7);
    apply_reset();
    idle(8);
    step(1'b1, 1'b0, 32'h7);
    step(1'b1, 1'b0, 32'h7);
    idle(8);

    // Random traffic on all three configurations
    for (int i = 0; i < 10000; i++) begin
      for (int id = 0; id < 3; id++) begin
        v   = ($urandom_range(0, 99) < 75);
        c   = ($urandom_range(0, 19) == 0);
        sel = $urandom_range(0, 9);
        f   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom();
        drive(id, v, c, f);
      end
      @(negedge clk);
    end
    idle(10);
    for (int id = 0; id < 3; id++) begin
      check_val($sformatf("cfg%0d.drain", id), 64'(exp_q[id].size()), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
